// File: rtl/riscv_data_mem.sv
// ============================================================================
// Module      : riscv_data_mem
// Description : Byte-addressed, word-organised synchronous data RAM with
//               1-cycle read latency, sub-word access, load extension,
//               misalignment detection and a post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_data_mem #(
    parameter int byte_addr_p = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [byte_addr_p-1:0] addr_i,
    input  logic                   rd_en_i,
    input  logic                   wr_en_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   valid_o,
    output logic                   misalign_o,
    output logic                   busy_o
);

    localparam int                c_WADDR    = byte_addr_p - 2;
    localparam int                c_DEPTH    = 2 ** c_WADDR;
    localparam logic [c_WADDR-1:0] c_LAST_IDX = c_WADDR'(c_DEPTH - 1);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_WADDR-1:0]   ptr_q, ptr_d;
    logic [31:0]          data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 misalign_q, misalign_d;
    logic                 busy_q, busy_d;
    logic [31:0]          mem_q [c_DEPTH];

    logic [c_WADDR-1:0]   w_widx;
    logic [1:0]           w_lane;
    logic                 w_aligned;
    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rword;
    logic [7:0]           w_rbyte;
    logic [15:0]          w_rhalf;
    logic [31:0]          w_rdata;

    assign w_widx = addr_i[byte_addr_p-1:2];
    assign w_lane = addr_i[1:0];

    always_comb begin
        w_aligned = 1'b0;
        case (size_i)
            c_SIZE_BYTE: w_aligned = 1'b1;
            c_SIZE_HALF: w_aligned = ~w_lane[0];
            c_SIZE_WORD: w_aligned = (w_lane == 2'b00);
            default:     w_aligned = 1'b0;
        endcase
    end

    // A write takes the port whenever both enables are raised.
    assign w_wr_fire = (state_q == READY) && wr_en_i && w_aligned;
    assign w_rd_fire = (state_q == READY) && rd_en_i && !wr_en_i && w_aligned;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = data_i;
        case (size_i)
            c_SIZE_BYTE: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{data_i[7:0]}};
            end
            c_SIZE_HALF: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_i[15:0]}};
            end
            c_SIZE_WORD: w_be = 4'b1111;
            default:     w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_rword = mem_q[w_widx];
        w_rbyte = w_rword[8*w_lane +: 8];
        w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
        case (size_i)
            c_SIZE_BYTE: w_rdata = unsigned_i ? {24'h0, w_rbyte}
                                              : {{24{w_rbyte[7]}}, w_rbyte};
            c_SIZE_HALF: w_rdata = unsigned_i ? {16'h0, w_rhalf}
                                              : {{16{w_rhalf[15]}}, w_rhalf};
            default:     w_rdata = w_rword;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == c_LAST_IDX) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                misalign_d = (rd_en_i || wr_en_i) && !w_aligned;
                valid_d    = w_rd_fire;
                if (w_rd_fire) begin
                    data_d = w_rdata;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            busy_q     <= busy_d;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it after every reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (w_wr_fire) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        mem_q[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign misalign_o = misalign_q;
    assign busy_o     = busy_q;

endmodule

`default_nettype wire
